inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 114 +++++++++++
 tb/tb_inst_fetch.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch sequencer: IDLE -> REQ -> WAIT handshake with instruction memory and PC load/redirect.
// Optional WAIT-state timeout with sticky error is enabled by defining IF_TIMEOUT_EN.
module inst_fetch #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        IF_CLK,
    input  logic        IF_RST,
    input  logic [31:0] IF_PC,
    input  logic        IF_START,
    input  logic        IF_REDIRECT,
    input  logic [31:0] IF_TARGET,
    output logic [31:0] IF_MEM_ADDR,
    output logic        IF_MEM_RDEN,
    input  logic [31:0] IF_MEM_DOUT,
    input  logic        IF_MEM_VALID,
    output logic [31:0] IF_IR,
    output logic        IF_IR_VALID,
    output logic [31:0] IF_NEXT_PC,
    output logic        IF_PC_LD,
    output logic        IF_BUSY,
    output logic        IF_ERR
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t state;

    // Elaboration-time guard on the timeout limit.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("inst_fetch: TIMEOUT must be in 1..255");
    end

`ifdef IF_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt;
`endif

    always_ff @(posedge IF_CLK) begin
        if (IF_RST) begin
            state       <= S_IDLE;
            IF_MEM_ADDR <= 32'd0;
            IF_MEM_RDEN <= 1'b0;
            IF_IR       <= 32'd0;
            IF_IR_VALID <= 1'b0;
            IF_NEXT_PC  <= 32'd0;
            IF_PC_LD    <= 1'b0;
            IF_BUSY     <= 1'b0;
            IF_ERR      <= 1'b0;
`ifdef IF_TIMEOUT_EN
            cnt         <= '0;
`endif
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            IF_MEM_RDEN <= 1'b0;
            IF_IR_VALID <= 1'b0;
            IF_PC_LD    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (IF_REDIRECT) begin
                        IF_NEXT_PC <= IF_TARGET;
                        IF_PC_LD   <= 1'b1;
                    end else if (IF_START) begin
                        IF_MEM_ADDR <= IF_PC;
                        IF_MEM_RDEN <= 1'b1;
                        IF_BUSY     <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    state <= S_WAIT;
`ifdef IF_TIMEOUT_EN
                    cnt   <= '0;
`endif
                end
                S_WAIT: begin
                    // Data arriving on the timeout edge still completes the fetch.
                    if (IF_MEM_VALID) begin
                        IF_IR       <= IF_MEM_DOUT;
                        IF_IR_VALID <= 1'b1;
                        IF_NEXT_PC  <= IF_MEM_ADDR + 32'd4;
                        IF_PC_LD    <= 1'b1;
                        IF_BUSY     <= 1'b0;
                        state       <= S_IDLE;
                    end
`ifdef IF_TIMEOUT_EN
                    else if (cnt == CNT_LAST) begin
                        IF_ERR  <= 1'b1;
                        IF_BUSY <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    IF_BUSY <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

`ifndef IF_TIMEOUT_EN
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W == 8);
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized self-checking bench for inst_fetch; a transaction-level model predicts every output cycle by cycle.
// Define IF_TIMEOUT_EN for both the DUT and this bench to exercise the timeout path.
module tb_inst_fetch;

    localparam int unsigned TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = 32'd0;
    logic        start = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] target = 32'd0;
    logic [31:0] mem_addr;
    logic        mem_rden;
    logic [31:0] mem_dout = 32'd0;
    logic        mem_valid = 1'b0;
    logic [31:0] ir;
    logic        ir_valid;
    logic [31:0] next_pc;
    logic        pc_ld;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural expectations that persist between events.
    logic [31:0] exp_ir   = 32'd0;
    logic [31:0] exp_npc  = 32'd0;
    logic [31:0] exp_addr = 32'd0;
    logic        exp_err  = 1'b0;

    inst_fetch #(.TIMEOUT(TO)) dut (
        .IF_CLK      (clk),
        .IF_RST      (rst),
        .IF_PC       (pc),
        .IF_START    (start),
        .IF_REDIRECT (redirect),
        .IF_TARGET   (target),
        .IF_MEM_ADDR (mem_addr),
        .IF_MEM_RDEN (mem_rden),
        .IF_MEM_DOUT (mem_dout),
        .IF_MEM_VALID(mem_valid),
        .IF_IR       (ir),
        .IF_IR_VALID (ir_valid),
        .IF_NEXT_PC  (next_pc),
        .IF_PC_LD    (pc_ld),
        .IF_BUSY     (busy),
        .IF_ERR      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input logic b, input logic rd, input logic irv, input logic ld);
        check("busy",     32'(busy),     32'(b));
        check("rden",     32'(mem_rden), 32'(rd));
        check("ir_valid", 32'(ir_valid), 32'(irv));
        check("pc_ld",    32'(pc_ld),    32'(ld));
        check("ir",       ir,            exp_ir);
        check("next_pc",  next_pc,       exp_npc);
        check("mem_addr", mem_addr,      exp_addr);
        check("err",      32'(err),      32'(exp_err));
    endtask

    // One fetch; data is returned d cycles after the RDEN cycle (d WAIT cycles).
    task automatic do_fetch(input logic [31:0] fpc, input logic [31:0] data, input int d);
        pc       = fpc;
        start    = 1'b1;
        redirect = 1'b0;
        tick();
        exp_addr = fpc;
        for (int c = 1; c <= 1 + d; c++) begin
            check_outputs(1'b1, c == 1, 1'b0, 1'b0);
            start    = 1'($urandom);
            redirect = 1'($urandom);
            target   = $urandom;
            pc       = $urandom;
            if (c == 1 + d) begin
                mem_valid = 1'b1;
                mem_dout  = data;
            end else begin
                mem_valid = (c == 1) ? 1'($urandom) : 1'b0;
                mem_dout  = $urandom;
            end
            tick();
        end
        mem_valid = 1'b0;
        start     = 1'b0;
        redirect  = 1'b0;
        exp_ir    = data;
        exp_npc   = fpc + 32'd4;
        check_outputs(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check_outputs(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_redirect(input logic [31:0] tgt, input logic with_start);
        redirect = 1'b1;
        start    = with_start;
        target   = tgt;
        pc       = $urandom;
        tick();
        redirect = 1'b0;
        start    = 1'b0;
        exp_npc  = tgt;
        check_outputs(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_outputs(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_reset_values();
        exp_ir   = 32'd0;
        exp_npc  = 32'd0;
        exp_addr = 32'd0;
        exp_err  = 1'b0;
        check_outputs(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Power-on reset, with a start request that must lose to reset.
        rst   = 1'b1;
        start = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
        start = 1'b0;
        expect_reset_values();
        tick();
        check_outputs(1'b0, 1'b0, 1'b0, 1'b0);

        do_fetch(32'h0000_0100, 32'h0050_0093, 1);
        do_fetch(32'hFFFF_FFFC, 32'hDEAD_BEEF, 1);
        check("wrap_npc", next_pc, 32'h0000_0000);
        do_redirect(32'h0000_2000, 1'b1);
        do_fetch(32'h0000_0203, 32'h1234_5678, 4);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0)
                do_redirect($urandom, 1'($urandom));
            else
                do_fetch($urandom, $urandom, int'($urandom_range(1, 6)));
        end

        // Reset while waiting on memory, with late data afterwards.
        pc    = 32'h0000_0400;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("busy_pre_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        mem_valid = 1'b1;
        mem_dout  = $urandom;
        expect_reset_values();
        tick();
        mem_valid = 1'b0;
        check_outputs(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_outputs(1'b0, 1'b0, 1'b0, 1'b0);

        // Data landing on the last permissible WAIT cycle.
        do_fetch(32'h0000_0800, 32'hCAFE_F00D, TO);

`ifdef IF_TIMEOUT_EN
        // Memory never answers: timeout after TO WAIT cycles.
        pc    = 32'h0000_0C00;
        start = 1'b1;
        tick();
        start    = 1'b0;
        exp_addr = 32'h0000_0C00;
        for (int c = 1; c <= 1 + int'(TO); c++) begin
            check_outputs(1'b1, c == 1, 1'b0, 1'b0);
            tick();
        end
        exp_err = 1'b1;
        check_outputs(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_outputs(1'b0, 1'b0, 1'b0, 1'b0);
        do_fetch(32'h0000_0D00, 32'h0000_0013, 2);
        check("err_sticky", 32'(err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_reset_values();
`else
        // No timeout: WAIT persists well beyond TO cycles.
        do_fetch(32'h0000_0C00, 32'h0000_0013, int'(TO) + 6);
        check("err_tied", 32'(err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
